// File: rtl/mem_stream_pkg.sv
// rtl/mem_stream_pkg.sv - shared codes, output field offsets, FSM encoding and header word builder
package mem_stream_pkg;

  localparam int IDLE_CODE   = 0;
  localparam int PAYLOAD_LSB = 0;
  localparam int MAX_W       = 256;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int code_lsb(input int dat_w);
    return dat_w;
  endfunction

  function automatic int bx_msb(input int dat_w, input int sel_w, input int bx_w);
    return dat_w + sel_w + bx_w - 1;
  endfunction

  // Header code is the all-ones value of a sel_w-bit code field.
  function automatic logic [MAX_W-1:0] hdr_code(input int sel_w);
    return (MAX_W'(1) << sel_w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] hdr_word(input logic [MAX_W-1:0] bx,
                                                input logic [MAX_W-1:0] cnt,
                                                input int dat_w, input int sel_w);
    return cnt | (hdr_code(sel_w) << dat_w) | (bx << (dat_w + sel_w));
  endfunction

endpackage

// File: rtl/bx_word_counter.sv
// rtl/bx_word_counter.sv - saturating per-BX data word counter; cnt is the closing count of the BX
module bx_word_counter
  import mem_stream_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             restart,
  input  logic             restart_one,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = restart_one ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_stream_mux.sv
// rtl/mem_stream_mux.sv - selects one memory read port by channel code and registers {bx, code, data}
module mem_stream_mux
  import mem_stream_pkg::*;
#(
  parameter int N_CH  = 12,
  parameter int DAT_W = 45,
  parameter int BX_W  = 3,
  parameter int SEL_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BX_W-1:0]             bx,
  input  logic                        bx_start,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        sel_valid,
  output logic                        in_ready,
  input  logic [N_CH*DAT_W-1:0]       mem_dat,
  output logic [BX_W+SEL_W+DAT_W-1:0] mem_dat_stream,
  output logic                        stream_valid,
  input  logic                        err_clr,
  output logic                        err_sel,
  output logic                        err_ovf
);

  localparam int OUT_W = BX_W + SEL_W + DAT_W;
  localparam int C_LSB = code_lsb(DAT_W);
  localparam int B_MSB = bx_msb(DAT_W, SEL_W, BX_W);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] stream_q, stream_d;
  logic [OUT_W-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             err_sel_q, err_sel_d;
  logic             err_ovf_q, err_ovf_d;

  logic [CNT_W-1:0] cnt_close;
  logic [DAT_W-1:0] mux_dat;
  logic [OUT_W-1:0] data_word, hdr_w;
  logic             ready, legal, illegal, data_acc, hdr_acc;

  assign ready    = (state_q == ST_RUN);
  assign legal    = sel_valid && (sel != SEL_W'(IDLE_CODE)) && (sel <= SEL_W'(N_CH));
  assign illegal  = sel_valid && (sel > SEL_W'(N_CH));
  assign data_acc = ready && legal;
  assign hdr_acc  = ready && bx_start;

  always_comb begin
    mux_dat = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k + 1)) mux_dat = mem_dat[k*DAT_W +: DAT_W];
    end
  end

  always_comb begin
    data_word = '0;
    data_word[B_MSB -: BX_W]        = bx;
    data_word[C_LSB +: SEL_W]       = sel;
    data_word[PAYLOAD_LSB +: DAT_W] = mux_dat;
  end

  assign hdr_w = OUT_W'(hdr_word(MAX_W'(bx), MAX_W'(cnt_close), DAT_W, SEL_W));

  bx_word_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .inc         (data_acc),
    .restart     (hdr_acc),
    .restart_one (data_acc & hdr_acc),
    .cnt         (cnt_close)
  );

  // A data word colliding with a header is parked and emitted one cycle later.
  always_comb begin
    state_d  = state_q;
    stream_d = stream_q;
    pend_d   = pend_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hdr_acc) begin
          stream_d = hdr_w;
          valid_d  = 1'b1;
          if (data_acc) begin
            pend_d  = data_word;
            state_d = ST_FLUSH;
          end
        end else if (data_acc) begin
          stream_d = data_word;
          valid_d  = 1'b1;
        end
      end
      ST_FLUSH: begin
        stream_d = pend_q;
        valid_d  = 1'b1;
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    err_sel_d = err_sel_q;
    err_ovf_d = err_ovf_q;
    if (err_clr) begin
      err_sel_d = 1'b0;
      err_ovf_d = 1'b0;
    end
    if (illegal) err_sel_d = 1'b1;
    if (!ready && (legal || bx_start)) err_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      stream_q  <= '0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      err_sel_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stream_q  <= stream_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      err_sel_q <= err_sel_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign in_ready       = ready;
  assign mem_dat_stream = stream_q;
  assign stream_valid   = valid_q;
  assign err_sel        = err_sel_q;
  assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_mem_stream_mux.sv
// tb/tb_mem_stream_mux.sv - directed and randomized checks of mem_stream_mux against a word-level model
module tb_mem_stream_mux;

  localparam int N_CH  = 12;
  localparam int DAT_W = 45;
  localparam int BX_W  = 3;
  localparam int SEL_W = 4;
  localparam int OUT_W = BX_W + SEL_W + DAT_W;

  logic                  clk = 1'b0;
  logic                  reset, bx_start, sel_valid, err_clr;
  logic [BX_W-1:0]       bx;
  logic [SEL_W-1:0]      sel;
  logic [N_CH*DAT_W-1:0] mem_dat;

  logic             in_ready, stream_valid, err_sel, err_ovf;
  logic [OUT_W-1:0] stream;
  logic             ready4, valid4, esel4, eovf4;
  logic [OUT_W-1:0] stream4;

  int checks = 0;
  int errors = 0;

  int               m_cnt;
  bit               m_flush;
  logic [OUT_W-1:0] m_pend, e_stream, e_stream4;
  bit               e_valid, e_sel, e_ovf;

  always #5 clk = ~clk;

  mem_stream_mux dut (
    .clk(clk), .reset(reset), .bx(bx), .bx_start(bx_start), .sel(sel), .sel_valid(sel_valid),
    .in_ready(in_ready), .mem_dat(mem_dat), .mem_dat_stream(stream), .stream_valid(stream_valid),
    .err_clr(err_clr), .err_sel(err_sel), .err_ovf(err_ovf)
  );

  mem_stream_mux #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bx(bx), .bx_start(bx_start), .sel(sel), .sel_valid(sel_valid),
    .in_ready(ready4), .mem_dat(mem_dat), .mem_dat_stream(stream4), .stream_valid(valid4),
    .err_clr(err_clr), .err_sel(esel4), .err_ovf(eovf4)
  );

  function automatic logic [DAT_W-1:0] chan(input int k);
    return mem_dat[k*DAT_W +: DAT_W];
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic idle_inputs();
    bx_start  = 1'b0;
    sel_valid = 1'b0;
    sel       = '0;
    err_clr   = 1'b0;
    reset     = 1'b0;
  endtask

  // Advance the model on the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit legal, illegal, ready;
    ready   = !m_flush;
    legal   = sel_valid && (int'(sel) >= 1) && (int'(sel) <= N_CH);
    illegal = sel_valid && (int'(sel) > N_CH);
    if (reset) begin
      m_cnt = 0; m_flush = 0; m_pend = '0;
      e_stream = '0; e_stream4 = '0; e_valid = 0; e_sel = 0; e_ovf = 0;
    end else begin
      e_sel = illegal ? 1'b1 : (err_clr ? 1'b0 : e_sel);
      e_ovf = (!ready && (legal || bx_start)) ? 1'b1 : (err_clr ? 1'b0 : e_ovf);
      if (!ready) begin
        e_stream = m_pend; e_stream4 = m_pend; e_valid = 1; m_flush = 0;
      end else if (bx_start) begin
        e_stream  = {bx, 4'hF, 45'(sat(m_cnt, 255))};
        e_stream4 = {bx, 4'hF, 45'(sat(m_cnt, 15))};
        e_valid   = 1;
        if (legal) begin
          m_pend = {bx, sel, chan(int'(sel) - 1)}; m_flush = 1; m_cnt = 1;
        end else begin
          m_cnt = 0;
        end
      end else if (legal) begin
        e_stream = {bx, sel, chan(int'(sel) - 1)}; e_stream4 = e_stream; e_valid = 1; m_cnt++;
      end else begin
        e_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_mem();
    for (int k = 0; k < N_CH; k++) mem_dat[k*DAT_W +: DAT_W] = 45'(k + 'h100);
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (stream !== '0) begin errors++; $display("FAIL rst_stream got %h exp 0", stream); end
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", stream_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    checks++; if (err_sel !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b exp 00", err_sel, err_ovf); end
  endtask

  task automatic test_channels();
    logic [OUT_W-1:0] exp;
    idle_inputs(); bx = 3'd5; sel_valid = 1'b1;
    for (int s = 1; s <= N_CH + 1; s++) begin
      sel = (s <= N_CH) ? 4'(s) : 4'd10;
      tick();
      exp = {3'd5, sel, 45'(int'(sel) - 1 + 'h100)};
      checks++; if (stream !== exp) begin errors++; $display("FAIL ch_word sel=%0d got %h exp %h", sel, stream, exp); end
      checks++; if (stream_valid !== 1'b1) begin errors++; $display("FAIL ch_valid sel=%0d got %b exp 1", sel, stream_valid); end
    end
    idle_inputs(); tick();
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", stream_valid); end
    checks++; if (stream !== {3'd5, 4'd10, 45'h109}) begin errors++; $display("FAIL idle_hold got %h exp %h", stream, {3'd5, 4'd10, 45'h109}); end
  endtask

  task automatic test_header();
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    bx = 3'd1; sel_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin sel = 4'($urandom_range(1, N_CH)); tick(); end
    sel_valid = 1'b0; bx = 3'd2; bx_start = 1'b1; tick();
    checks++; if (stream !== {3'd2, 4'hF, 45'd7} || stream_valid !== 1'b1) begin errors++; $display("FAIL hdr_7 got %h v%b exp %h", stream, stream_valid, {3'd2, 4'hF, 45'd7}); end
    bx_start = 1'b0; tick();
    bx = 3'd3; bx_start = 1'b1; tick(); bx_start = 1'b0;
    checks++; if (stream !== {3'd3, 4'hF, 45'd0}) begin errors++; $display("FAIL hdr_0 got %h exp %h", stream, {3'd3, 4'hF, 45'd0}); end
  endtask

  task automatic test_flush();
    idle_inputs(); bx = 3'd4; sel_valid = 1'b1;
    sel = 4'd1; tick(); sel = 4'd2; tick();
    sel = 4'd3; bx_start = 1'b1; tick();
    checks++; if (stream !== {3'd4, 4'hF, 45'd2}) begin errors++; $display("FAIL fl_hdr got %h exp %h", stream, {3'd4, 4'hF, 45'd2}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", in_ready); end
    bx_start = 1'b0; sel = 4'd1; tick();
    checks++; if (stream !== {3'd4, 4'd3, 45'h102} || stream_valid !== 1'b1) begin errors++; $display("FAIL fl_data got %h v%b exp %h", stream, stream_valid, {3'd4, 4'd3, 45'h102}); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL fl_ovf got %b exp 1", err_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_ready2 got %b exp 1", in_ready); end
    sel_valid = 1'b0; tick();
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL fl_drop got %b exp 0", stream_valid); end
    bx = 3'd6; bx_start = 1'b1; tick(); bx_start = 1'b0;
    checks++; if (stream !== {3'd6, 4'hF, 45'd1}) begin errors++; $display("FAIL fl_cnt1 got %h exp %h", stream, {3'd6, 4'hF, 45'd1}); end
  endtask

  task automatic test_errors();
    idle_inputs(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err_ovf !== 1'b0 || err_sel !== 1'b0) begin errors++; $display("FAIL er_clr got %b%b exp 00", err_sel, err_ovf); end
    sel = 4'd13; sel_valid = 1'b1; tick();
    checks++; if (stream_valid !== 1'b0 || err_sel !== 1'b1) begin errors++; $display("FAIL er_13 got v%b e%b exp v0 e1", stream_valid, err_sel); end
    sel_valid = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL er_clr13 got %b exp 0", err_sel); end
    sel = 4'd15; sel_valid = 1'b1; tick();
    checks++; if (stream_valid !== 1'b0 || err_sel !== 1'b1) begin errors++; $display("FAIL er_15 got v%b e%b exp v0 e1", stream_valid, err_sel); end
    sel_valid = 1'b0; err_clr = 1'b1; tick();
    sel = 4'd14; sel_valid = 1'b1; tick();
    checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL er_prio got %b exp 1", err_sel); end
    sel_valid = 1'b0; tick(); err_clr = 1'b0;
  endtask

  task automatic test_saturation();
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    bx = 3'd7; sel_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin sel = 4'($urandom_range(1, N_CH)); tick(); end
    sel_valid = 1'b0; bx_start = 1'b1; tick(); bx_start = 1'b0;
    checks++; if (stream4 !== {3'd7, 4'hF, 45'd15}) begin errors++; $display("FAIL sat4 got %h exp %h", stream4, {3'd7, 4'hF, 45'd15}); end
    checks++; if (stream !== {3'd7, 4'hF, 45'd20}) begin errors++; $display("FAIL cnt20 got %h exp %h", stream, {3'd7, 4'hF, 45'd20}); end
    sel_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin sel = 4'($urandom_range(1, N_CH)); tick(); end
    sel_valid = 1'b0; tick();
    bx_start = 1'b1; tick(); bx_start = 1'b0;
    checks++; if (stream !== {3'd7, 4'hF, 45'd255}) begin errors++; $display("FAIL sat8 got %h exp %h", stream, {3'd7, 4'hF, 45'd255}); end
  endtask

  task automatic test_reset_flush();
    idle_inputs(); bx = 3'd1; sel = 4'd5; sel_valid = 1'b1; bx_start = 1'b1; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rf_ready got %b exp 0", in_ready); end
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (stream_valid !== 1'b0 || in_ready !== 1'b1 || stream !== '0) begin errors++; $display("FAIL rf_abort got v%b r%b %h exp v0 r1 0", stream_valid, in_ready, stream); end
    tick();
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL rf_nodata got %b exp 0", stream_valid); end
    bx = 3'd2; bx_start = 1'b1; tick(); bx_start = 1'b0;
    checks++; if (stream !== {3'd2, 4'hF, 45'd0}) begin errors++; $display("FAIL rf_hdr got %h exp %h", stream, {3'd2, 4'hF, 45'd0}); end
  endtask

  task automatic test_random();
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bx        = 3'($urandom);
      sel       = 4'($urandom);
      sel_valid = 1'($urandom_range(0, 1));
      bx_start  = ($urandom_range(0, 5) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N_CH; k++) mem_dat[k*DAT_W +: DAT_W] = 45'({$urandom, $urandom});
      tick();
      checks++; if (stream_valid !== e_valid) begin errors++; $display("FAIL rnd_valid i=%0d got %b exp %b", i, stream_valid, e_valid); end
      checks++; if (stream !== e_stream) begin errors++; $display("FAIL rnd_stream i=%0d got %h exp %h", i, stream, e_stream); end
      checks++; if (stream4 !== e_stream4) begin errors++; $display("FAIL rnd_stream4 i=%0d got %h exp %h", i, stream4, e_stream4); end
      checks++; if (in_ready !== !m_flush) begin errors++; $display("FAIL rnd_ready i=%0d got %b exp %b", i, in_ready, !m_flush); end
      checks++; if (err_sel !== e_sel || err_ovf !== e_ovf) begin errors++; $display("FAIL rnd_err i=%0d got %b%b exp %b%b", i, err_sel, err_ovf, e_sel, e_ovf); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1; bx = '0;
    m_cnt = 0; m_flush = 0; m_pend = '0;
    e_stream = '0; e_stream4 = '0; e_valid = 0; e_sel = 0; e_ovf = 0;
    set_fixed_mem();
    #2;
    test_reset();
    test_channels();
    test_header();
    test_flush();
    test_errors();
    test_saturation();
    set_fixed_mem();
    test_reset_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stream_mux.md
Name: mem_stream_mux

Overview:
- Parametrised successor to the fixed 12-way memory-to-stream mux.
- Selects one of N_CH memory read ports by binary-encoded channel code and registers {BX, code, data} onto a single output stream.
- Adds per-BX header insertion, a contiguous channel code map, explicit stream valid, upstream ready, and sticky error flags.
- Sits between the memory read-address priority encoder and the link serializer.

Parameters:
- N_CH, 12, number of memory input channels; 1 <= N_CH <= 2^SEL_W-2.
- DAT_W, 45, width of each memory data word.
- BX_W, 3, bunch-crossing tag width.
- SEL_W, 4, channel code width.
- CNT_W, 8, per-BX word counter width; CNT_W <= DAT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bx  in  BX_W  current BX tag, sampled with sel/bx_start.
- bx_start  in  1  one-cycle pulse marking first cycle of a new BX.
- sel  in  SEL_W  channel code: 0 = idle, k = channel k-1, all-ones = header (reserved).
- sel_valid  in  1  sel qualifies a data request this cycle.
- in_ready  out  1  block accepts sel_valid/bx_start this cycle.
- mem_dat  in  N_CH*DAT_W  flattened inputs; channel k at [k*DAT_W +: DAT_W].
- mem_dat_stream  out  BX_W+SEL_W+DAT_W  output word {bx, code, payload}.
- stream_valid  out  1  mem_dat_stream holds a new word this cycle.
- err_clr  in  1  clears sticky error flags.
- err_sel  out  1  sticky: illegal code (N_CH < sel) presented with sel_valid.
- err_ovf  out  1  sticky: request presented while in_ready=0.

Behaviour:
- Reset (synchronous): mem_dat_stream=0, stream_valid=0, in_ready=1, err_sel=0, err_ovf=0, word count=0, pending register empty, FSM=RUN. Reset mid-operation discards any pending word; no header is emitted for the aborted BX.
- Latency: 1 cycle from accepted request to output. bx, sel and mem_dat are sampled in the same cycle.
- Data accept at t (in_ready=1, sel_valid=1, 1<=sel<=N_CH): at t+1, stream={bx, sel, mem_dat[sel-1]} and stream_valid=1. Word count increments, saturating at 2^CNT_W-1.
- sel=0 with sel_valid: ignored, no error.
- sel>N_CH with sel_valid (including all-ones): word dropped, err_sel set, count unchanged.
- Header on bx_start at t (in_ready=1): at t+1, stream={bx, all-ones, count zero-extended to DAT_W} and stream_valid=1. count = data words accepted since the previous bx_start or reset, excluding any word accepted in cycle t. Count then restarts at 0, or at 1 if a data word was also accepted at t.
- FSM RUN: bx_start without a legal data request -> header at t+1, stay RUN.
- FSM RUN: bx_start plus a legal data request at t -> header at t+1, data word captured in pending register, go to FLUSH.
- FSM FLUSH (one cycle, t+1): in_ready=0; pending word emitted at t+2 with its original bx/sel; return to RUN.
- Any sel_valid (legal code) or bx_start presented in FLUSH is dropped and sets err_ovf. Upstream must space bx_start at least 2 cycles apart.
- Idle cycles: stream_valid=0 and mem_dat_stream holds its last value.
- Sticky flags: set has priority over err_clr in the same cycle; err_clr alone clears both flags on the next edge.
- mem_dat_stream is fully registered with no combinational input-to-output path. in_ready is decoded from FSM state only.

Decomposition:
- Package mem_stream_pkg holds:
  - constants IDLE_CODE=0 and HDR_CODE=all-ones;
  - output field offsets (payload LSB, code, BX MSB);
  - FSM state encoding RUN/FLUSH;
  - a function building a header word from bx and count.
- Sub-module bx_word_counter: saturating CNT_W counter with inc, restart and restart-with-one inputs, emitting the closing count.
- Mux, pending register and FSM stay in the top.

Test Plan:
- Defaults, reset then sel_valid with sel=1..12 on consecutive cycles, mem_dat[k]=k+0x100, bx=5 -> twelve words {5, k+1, k+0x100} at t+1, stream_valid high 12 cycles; sel=10 (old gap code) returns channel 9.
- bx_start alone after 7 accepted words, bx=2 -> next cycle header {2, 0xF, 45'd7}; next BX count restarts at 0.
- bx_start and sel=3 same cycle, bx=4 -> header (count of prior BX) at t+1, in_ready=0 at t+1, data {4, 3, ch2} at t+2; a sel_valid with sel=1 at t+1 is dropped and err_ovf=1.
- sel=13, then sel=15 with sel_valid -> no stream_valid, err_sel=1; err_clr pulse clears it; err_clr coincident with new sel=14 leaves err_sel=1.
- CNT_W=4, 20 words then bx_start -> header payload 15 (saturated).
- Reset asserted while FSM=FLUSH -> no data word at t+2, stream_valid=0, in_ready=1, the next header after bx_start carries count 0.
